cla_serial_word_adder: RTL

//  Multi-cycle WIDTH-bit adder built on the 4-bit augmented CLA slice.
//  - Processes one nibble per cycle, LSB first; the nibble carry is registered between cycles.
//  - Accumulates the word-level block propagate and generate (P, G) from the per-nibble P/G.
//  - Sits between the ALU operand latch (upstream, valid/ready) and the writeback/flag stage
//    (downstream, valid/ready); trades latency for area.

---
 rtl/cla_serial_word_adder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cla_serial_word_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit CLA slice reused LSB-first with a registered carry,
// accumulating word-level propagate/generate; valid/ready on both sides.
module cla_serial_word_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             word_p,
    output logic             word_g
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             wp_q, wp_d, wg_q, wg_d;

    logic [CW+1:0]    nib_idx;
    logic [3:0]       na, nb, np, ng, ns;
    logic [4:0]       c;
    logic             slice_p, slice_g;

    // 4-bit augmented CLA slice on the current nibble, carry-in from the carry register
    always_comb begin
        nib_idx = {cnt_q, 2'b00};
        na      = a_q[nib_idx +: 4];
        nb      = b_q[nib_idx +: 4];
        np      = na ^ nb;
        ng      = na & nb;
        slice_p = &np;
        slice_g = ng[3] | (np[3] & ng[2]) | (np[3] & np[2] & ng[1])
                | (np[3] & np[2] & np[1] & ng[0]);
        c[0]    = carry_q;
        c[1]    = ng[0] | (np[0] & c[0]);
        c[2]    = ng[1] | (np[1] & ng[0]) | (np[1] & np[0] & c[0]);
        c[3]    = ng[2] | (np[2] & ng[1]) | (np[2] & np[1] & ng[0])
                | (np[2] & np[1] & np[0] & c[0]);
        c[4]    = slice_g | (slice_p & c[0]);
        ns      = np ^ c[3:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        wp_d    = wp_q;
        wg_d    = wg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    wp_d    = 1'b1;
                    wg_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[nib_idx +: 4] = ns;
                carry_d = c[4];
                wg_d    = slice_g | (slice_p & wg_q);
                wp_d    = wp_q & slice_p;
                if (cnt_q == LAST) begin
                    // c[3] of the top slice is the carry into the word MSB
                    cout_d  = c[4];
                    ovf_d   = c[3] ^ c[4];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wp_q    <= 1'b0;
            wg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            wp_q    <= wp_d;
            wg_q    <= wg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign word_p    = wp_q;
    assign word_g    = wg_q;

endmodule
